// File: rtl/free_list_pkg.sv
// Shared rename/ROB/free-list types: preg and ROB tag widths, free-list pointer with wrap bit.
package free_list_pkg;

  localparam int NUM_PREG  = 128;
  localparam int NUM_ARCH  = 32;
  localparam int ROB_DEPTH = 16;
  localparam int PREG_W    = $clog2(NUM_PREG);
  localparam int ROB_TAG_W = 5;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [PREG_W:0]      fl_ptr_t;   // index bits plus wrap bit

  // ROB tags are one bit wider than the table index; fold them onto the table depth.
  function automatic rob_idx_t tag_idx(rob_tag_t tag);
    return rob_idx_t'(tag % rob_tag_t'(ROB_DEPTH));
  endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/ROB-facing port bundle of the free list; master = rename+ROB, slave = free list.
interface free_list_if;
  import free_list_pkg::*;

  logic     alloc_req;
  logic     alloc_need;
  rob_tag_t alloc_tag;
  preg_t    alloc_preg;
  logic     empty;
  fl_ptr_t  free_cnt;
  logic     retire_valid;
  preg_t    retire_preg;
  logic     mispredict;
  rob_tag_t mispredict_tag;
  logic     dbl_free;

  modport master (
    output alloc_req, alloc_need, alloc_tag, retire_valid, retire_preg, mispredict, mispredict_tag,
    input  alloc_preg, empty, free_cnt, dbl_free
  );

  modport slave (
    input  alloc_req, alloc_need, alloc_tag, retire_valid, retire_preg, mispredict, mispredict_tag,
    output alloc_preg, empty, free_cnt, dbl_free
  );

endinterface

// File: rtl/fl_snapshot_table.sv
// Per-ROB-tag copy of the free-list read pointer, used to rewind on mispredict.
// Latency: write lands on posedge clk; read is asynchronous.
// Backpressure: none; one write and one read per cycle always accepted.
module fl_snapshot_table
  import free_list_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     we,
  input  rob_tag_t waddr,
  input  fl_ptr_t  wdata,
  input  rob_tag_t raddr,
  output fl_ptr_t  rdata
);

  fl_ptr_t snap [ROB_DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) snap[i] <= '0;
    end else if (we) begin
      snap[tag_idx(waddr)] <= wdata;
    end
  end

  assign rdata = snap[tag_idx(raddr)];

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for rename; FREE_LIST_DUPCHK_EN adds a double-free detector.
// Latency: grant is combinational from the head entry; pointers, storage and snapshots update on posedge clk.
// Backpressure: retire pushes are always accepted; rename must stall on empty when it needs a preg.
module free_list
  import free_list_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  free_list_if.slave fl
);

  preg_t   mem [NUM_PREG];
  fl_ptr_t rd_ptr;
  fl_ptr_t wr_ptr;
  fl_ptr_t snap_rd;
  fl_ptr_t cnt;
  logic    empty;
  logic    pop;
  logic    push;
  logic    snap_we;

  assign cnt   = wr_ptr - rd_ptr;
  assign empty = (cnt == '0);
  // A squashed rename neither pops nor records a snapshot.
  assign pop     = fl.alloc_req & fl.alloc_need & ~empty & ~fl.mispredict;
  assign snap_we = fl.alloc_req & ~fl.mispredict;
  assign push    = fl.retire_valid;

  assign fl.free_cnt   = cnt;
  assign fl.empty      = empty;
  assign fl.alloc_preg = mem[preg_t'(rd_ptr)];

  fl_snapshot_table u_snap (
    .clk   (clk),
    .reset (reset),
    .we    (snap_we),
    .waddr (fl.alloc_tag),
    .wdata (rd_ptr + fl_ptr_t'(pop)),
    .raddr (fl.mispredict_tag),
    .rdata (snap_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= fl_ptr_t'(NUM_PREG - NUM_ARCH);
    end else begin
      if (fl.mispredict) begin
        rd_ptr <= snap_rd;
      end else if (pop) begin
        rd_ptr <= rd_ptr + fl_ptr_t'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + fl_ptr_t'(1);
      end
    end
  end

  // Entries behind rd_ptr are never overwritten before a rewind can reach them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREG; i++) begin
        mem[i] <= (i < NUM_PREG - NUM_ARCH) ? preg_t'(NUM_ARCH + i) : '0;
      end
    end else if (push) begin
      mem[preg_t'(wr_ptr)] <= fl.retire_preg;
    end
  end

`ifdef FREE_LIST_DUPCHK_EN
  logic [NUM_PREG-1:0] is_free;
  logic [NUM_PREG-1:0] is_free_nxt;
  logic                dbl_free_q;
  fl_ptr_t             restore_len;

  assign restore_len = rd_ptr - snap_rd;

  always_comb begin
    is_free_nxt = is_free;
    if (fl.mispredict) begin
      for (int k = 0; k < NUM_PREG; k++) begin
        if (fl_ptr_t'(k) < restore_len) begin
          is_free_nxt[mem[preg_t'(snap_rd + fl_ptr_t'(k))]] = 1'b1;
        end
      end
    end
    if (pop)  is_free_nxt[fl.alloc_preg]  = 1'b0;
    if (push) is_free_nxt[fl.retire_preg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREG; i++) is_free[i] <= (i >= NUM_ARCH);
      dbl_free_q <= 1'b0;
    end else begin
      is_free <= is_free_nxt;
      if (push && (is_free[fl.retire_preg] || fl.retire_preg == '0)) begin
        dbl_free_q <= 1'b1;
      end
    end
  end

  assign fl.dbl_free = dbl_free_q;
`else
  assign fl.dbl_free = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vector table, hand-written corner sequences, randomized run vs a queue model.
module tb_free_list;
  import free_list_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  free_list_if fl ();
  free_list dut (.clk(clk), .reset(reset), .fl(fl));

`ifdef FREE_LIST_DUPCHK_EN
  localparam logic [31:0] DUP_EN = 32'd1;
`else
  localparam logic [31:0] DUP_EN = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic     req;
    logic     need;
    rob_tag_t tag;
    logic     rv;
    preg_t    rp;
    logic     mp;
    rob_tag_t mt;
    preg_t    e_preg;
    fl_ptr_t  e_cnt;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(int req, int need, int tag, int rv, int rp, int mp, int mt, int ep, int ec);
    vec_t v;
    v.req = 1'(req);  v.need = 1'(need); v.tag = 5'(tag);
    v.rv  = 1'(rv);   v.rp   = 7'(rp);   v.mp  = 1'(mp);  v.mt = 5'(mt);
    v.e_preg = 7'(ep); v.e_cnt = 8'(ec);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    fl.alloc_req = 1'b0; fl.alloc_need = 1'b0; fl.alloc_tag = '0;
    fl.retire_valid = 1'b0; fl.retire_preg = '0;
    fl.mispredict = 1'b0; fl.mispredict_tag = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " cnt"},   fl.free_cnt,   96);
    chk({tag, " preg"},  fl.alloc_preg, 32);
    chk({tag, " empty"}, fl.empty,      0);
    chk({tag, " dbl"},   fl.dbl_free,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Randomized-phase reference model: free pregs as an ordered queue, grants since the
  // last commit kept in order so a rewind returns them to the head of the queue.
  preg_t free_q [$];
  preg_t hist   [$];
  preg_t pool   [$];
  int    total_pops;
  int    commit_mark;
  int    snap_m [ROB_DEPTH];

  initial begin
    tbl[0] = mk(1, 1, 0, 0, 0,    0, 0, 33, 95);
    tbl[1] = mk(1, 0, 1, 0, 0,    0, 0, 33, 95);
    tbl[2] = mk(1, 1, 2, 0, 0,    0, 0, 34, 94);
    tbl[3] = mk(1, 1, 3, 0, 0,    0, 0, 35, 93);
    tbl[4] = mk(0, 0, 0, 0, 0,    1, 1, 33, 95);
    tbl[5] = mk(1, 1, 5, 1, 'h10, 1, 0, 33, 96);
    tbl[6] = mk(0, 0, 0, 0, 0,    1, 5, 32, 97);
    tbl[7] = mk(1, 1, 6, 0, 0,    0, 0, 33, 96);
    tbl[8] = mk(0, 0, 0, 0, 0,    0, 0, 33, 96);

    reset = 1'b1;
    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 9; i++) begin
      idle();
      fl.alloc_req = tbl[i].req; fl.alloc_need = tbl[i].need; fl.alloc_tag = tbl[i].tag;
      fl.retire_valid = tbl[i].rv; fl.retire_preg = tbl[i].rp;
      fl.mispredict = tbl[i].mp; fl.mispredict_tag = tbl[i].mt;
      step();
      chk($sformatf("vec%0d preg", i),  fl.alloc_preg, tbl[i].e_preg);
      chk($sformatf("vec%0d cnt", i),   fl.free_cnt,   tbl[i].e_cnt);
      chk($sformatf("vec%0d empty", i), fl.empty,      0);
      chk($sformatf("vec%0d dbl", i),   fl.dbl_free,   0);
    end

    // Drain every free preg, then pop against an empty list and refill it.
    do_reset();
    for (int i = 0; i < 96; i++) begin
      idle();
      fl.alloc_req = 1'b1; fl.alloc_need = 1'b1; fl.alloc_tag = 5'(i % 16);
      chk($sformatf("drain grant%0d", i), fl.alloc_preg, 32 + i);
      step();
    end
    idle();
    chk("drained empty", fl.empty, 1);
    chk("drained cnt", fl.free_cnt, 0);
    fl.alloc_req = 1'b1; fl.alloc_need = 1'b1;
    step();
    chk("pop on empty cnt", fl.free_cnt, 0);
    fl.retire_valid = 1'b1; fl.retire_preg = 7'h21;
    chk("no bypass empty", fl.empty, 1);
    step();
    chk("refill empty", fl.empty, 0);
    chk("refill preg", fl.alloc_preg, 'h21);
    chk("refill cnt", fl.free_cnt, 1);

    // Pop and push together across the index wrap.
    for (int k = 0; k < 40; k++) begin
      idle();
      fl.alloc_req = 1'b1; fl.alloc_need = 1'b1; fl.alloc_tag = 5'(k % 16);
      fl.retire_valid = 1'b1; fl.retire_preg = 7'(40 + k);
      step();
      chk($sformatf("wrap%0d preg", k), fl.alloc_preg, 40 + k);
      chk($sformatf("wrap%0d cnt", k),  fl.free_cnt,   1);
    end

    // Asynchronous reset in the middle of a cycle with activity on the ports.
    fl.retire_preg = 7'd90;
    #3;
    reset = 1'b0;
    #1;
    chk_reset_state("async reset");
    step();
    reset = 1'b1;
    idle();
    chk_reset_state("after reset");

    // Double free: a still-free preg and p0.
    fl.retire_valid = 1'b1; fl.retire_preg = 7'd40;
    step();
    idle();
    chk("dup40 dbl", fl.dbl_free, DUP_EN);
    chk("dup40 cnt", fl.free_cnt, 97);
    step(); step(); step();
    chk("dup40 sticky", fl.dbl_free, DUP_EN);
    reset = 1'b0;
    #1;
    chk("dup40 cleared", fl.dbl_free, 0);
    step();
    reset = 1'b1;
    fl.retire_valid = 1'b1; fl.retire_preg = 7'd0;
    step();
    idle();
    chk("dup p0 dbl", fl.dbl_free, DUP_EN);

    // Randomized run against the queue model.
    do_reset();
    free_q = {}; hist = {}; pool = {};
    for (int p = 32; p < 128; p++) free_q.push_back(7'(p));
    for (int p = 1; p < 32; p++) pool.push_back(7'(p));
    total_pops = 0;
    commit_mark = 0;
    for (int t = 0; t < ROB_DEPTH; t++) snap_m[t] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      int   n;
      int   t;
      int   idx;
      logic mp;
      logic req;
      logic need;
      logic rv;
      int   mt;
      int   tag;
      preg_t rp;

      idle();
      chk("rnd cnt",   fl.free_cnt, free_q.size());
      chk("rnd empty", fl.empty,    free_q.size() == 0);
      chk("rnd dbl",   fl.dbl_free, 0);
      if (free_q.size() > 0) chk("rnd preg", fl.alloc_preg, free_q[0]);

      mp = 1'b0; mt = 0;
      if ($urandom_range(0, 9) == 0) begin
        t = int'($urandom_range(0, ROB_DEPTH - 1));
        if (snap_m[t] >= commit_mark && snap_m[t] <= total_pops) begin
          mp = 1'b1; mt = t;
        end
      end
      req  = ($urandom_range(0, 9) < 6);
      need = ($urandom_range(0, 3) != 0);
      tag  = int'($urandom_range(0, ROB_DEPTH - 1));
      rv   = (pool.size() > 0) && ($urandom_range(0, 9) < 4);
      rp   = '0;
      if (rv) begin
        idx = int'($urandom_range(0, pool.size() - 1));
        rp  = pool[idx];
        pool.delete(idx);
      end

      fl.alloc_req = req; fl.alloc_need = need; fl.alloc_tag = 5'(tag);
      fl.retire_valid = rv; fl.retire_preg = rp;
      fl.mispredict = mp; fl.mispredict_tag = 5'(mt);

      if (mp) begin
        n = total_pops - snap_m[mt];
        for (int j = 0; j < n; j++) free_q.push_front(hist.pop_back());
        total_pops = snap_m[mt];
      end else if (req) begin
        if (need && free_q.size() > 0) begin
          hist.push_back(free_q.pop_front());
          total_pops++;
        end
        snap_m[tag] = total_pops;
      end
      if (rv) free_q.push_back(rp);
      if ($urandom_range(0, 7) == 0) begin
        while (hist.size() > 0) pool.push_back(hist.pop_front());
        commit_mark = total_pops;
      end

      step();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
